// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner: 2-flop sync, debounce, press/release/long-press pulses.
// Define BTN_DEBOUNCE_AUTOREPEAT_EN to build the auto-repeat counters that drive rpt.
module btn_debounce_multi #(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned STABLE_MS  = 10,
    parameter int unsigned LONG_MS    = 1000,
    parameter int unsigned REPEAT_MS  = 200,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] rel,
    output logic [N_BTN-1:0] long_press,
    output logic [N_BTN-1:0] rpt
);
    localparam int unsigned CYC_PER_MS = CLOCK_FREQ / 1000;
    localparam int unsigned STABLE_CYC = STABLE_MS * CYC_PER_MS;
    localparam int unsigned LONG_CYC   = LONG_MS * CYC_PER_MS;
    localparam int unsigned STAB_W     = $clog2(STABLE_CYC + 1);
    localparam int unsigned HOLD_W     = $clog2(LONG_CYC + 1);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam int unsigned REPEAT_CYC = REPEAT_MS * CYC_PER_MS;
    localparam int unsigned RPT_W      = $clog2(REPEAT_CYC + 1);
`endif

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Reject configurations the counters cannot represent.
    if (N_BTN < 1 || N_BTN > 32 || (CLOCK_FREQ % 1000) != 0 || STABLE_MS < 1 ||
        LONG_MS < 1 || REPEAT_MS < 1 || CYC_PER_MS < 1) begin : g_bad_cfg
        $error("btn_debounce_multi: illegal parameter set");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [1:0]        sync_q;
        logic [STAB_W-1:0] stab_q;
        logic              lvl_q;
        logic              press_q;
        logic              rel_q;
        logic              long_q;
        logic              long_d;
        logic              toggle_c;
        logic              rise_c;
        logic              fall_c;
        state_t            state_q;
        state_t            state_d;
        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] hold_d;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        logic [RPT_W-1:0]  rcnt_q;
        logic [RPT_W-1:0]  rcnt_d;
        logic              rpt_q;
        logic              rpt_d;
`endif

        // Level flips once the synchronised input has disagreed for STABLE_CYC cycles.
        assign toggle_c = (sync_q[1] != lvl_q) && (stab_q == STAB_W'(STABLE_CYC - 1));
        assign rise_c   = toggle_c & ~lvl_q;
        assign fall_c   = toggle_c & lvl_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q  <= '0;
                stab_q  <= '0;
                lvl_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                sync_q  <= {sync_q[0], btn[i] ^ ACTIVE_LOW};
                if ((sync_q[1] == lvl_q) || toggle_c) begin
                    stab_q <= '0;
                end else begin
                    stab_q <= stab_q + STAB_W'(1);
                end
                if (toggle_c) begin
                    lvl_q <= ~lvl_q;
                end
                press_q <= rise_c;
                rel_q   <= fall_c;
            end
        end

        // Press-tracking FSM; a debounced fall always wins over long/repeat thresholds.
        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            long_d  = 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
            rcnt_d  = '0;
            rpt_d   = 1'b0;
`endif
            unique case (state_q)
                RELEASED: begin
                    if (rise_c) begin
                        state_d = PRESSED;
                        hold_d  = '0;
                    end
                end
                PRESSED: begin
                    hold_d = hold_q + HOLD_W'(1);
                    if (fall_c) begin
                        state_d = RELEASED;
                    end else if (hold_q == HOLD_W'(LONG_CYC - 1)) begin
                        state_d = HELD;
                        long_d  = 1'b1;
                    end
                end
                HELD: begin
                    if (fall_c) begin
                        state_d = RELEASED;
                    end
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                    else if (rcnt_q == RPT_W'(REPEAT_CYC - 1)) begin
                        rpt_d = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + RPT_W'(1);
                    end
`endif
                end
                default: state_d = RELEASED;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= RELEASED;
                hold_q  <= '0;
                long_q  <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                rcnt_q  <= '0;
                rpt_q   <= 1'b0;
`endif
            end else begin
                state_q <= state_d;
                hold_q  <= hold_d;
                long_q  <= long_d;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                rcnt_q  <= rcnt_d;
                rpt_q   <= rpt_d;
`endif
            end
        end

        assign level[i]      = lvl_q;
        assign press[i]      = press_q;
        assign rel[i]        = rel_q;
        assign long_press[i] = long_q;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        assign rpt[i]        = rpt_q;
`else
        assign rpt[i]        = 1'b0;
`endif
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: directed scenarios plus random traffic, checked every cycle
// against a timeline model (sample history windows and press timestamps).
module tb_btn_debounce_multi;
    localparam int unsigned N = 4;
    localparam int S = 4;
    localparam int L = 20;
    localparam int R = 5;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [N-1:0] btn;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] long_press;
    logic [N-1:0] rpt;
    logic [5*N-1:0] dut_vec;
    logic [5*N-1:0] exp_vec;

    assign dut_vec = {level, press, rel, long_press, rpt};

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: k counts clock edges since reset release.
    int           k;
    int           last_t  [N];
    int           press_t [N];
    logic [N-1:0] m_lvl;
    logic [N-1:0] bq [$];
    logic [N-1:0] sq [$];

    btn_debounce_multi #(
        .N_BTN(N), .CLOCK_FREQ(1000), .STABLE_MS(4), .LONG_MS(20), .REPEAT_MS(5), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .level(level), .press(press),
        .rel(rel), .long_press(long_press), .rpt(rpt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        k = 0;
        bq.delete();
        sq.delete();
        bq.push_back('0);
        sq.push_back('0);
        m_lvl   = '0;
        exp_vec = '0;
        for (int c = 0; c < int'(N); c++) begin
            last_t[c]  = 0;
            press_t[c] = 0;
        end
    endtask

    // Drive one cycle of input and advance the model to the state after that edge.
    task automatic step(input logic [N-1:0] v);
        logic [N-1:0] e_press, e_rel, e_long, e_rpt, sj, prev;
        bit all_diff;
        int d;
        btn = v;
        @(posedge clk);
        #1;
        k++;
        bq.push_back(v);
        prev = bq[k-1];
        sq.push_back((k >= 2) ? prev : '0);
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
        e_rpt   = '0;
        for (int c = 0; c < int'(N); c++) begin
            if (k - last_t[c] >= S) begin
                all_diff = 1'b1;
                for (int j = k - S; j < k; j++) begin
                    sj = sq[j];
                    if (sj[c] == m_lvl[c]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_lvl[c]  = ~m_lvl[c];
                    last_t[c] = k;
                    if (m_lvl[c]) begin
                        e_press[c] = 1'b1;
                        press_t[c] = k;
                    end else begin
                        e_rel[c] = 1'b1;
                    end
                end
            end
            if (m_lvl[c]) begin
                d = k - press_t[c];
                e_long[c] = (d == L);
                e_rpt[c]  = RPT_EN && (d > L) && (((d - L) % R) == 0);
            end
        end
        exp_vec = {m_lvl, e_press, e_rel, e_long, e_rpt};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn   = '1;
        repeat (3) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (dut_vec !== '0) begin
                n_fail++;
                $display("FAIL reset_hold dut=%h exp=0", dut_vec);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int j = 1; j <= 8; j++) begin
            step('1);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_seq j=%0d dut=%h exp=%h", j, dut_vec, exp_vec);
            end
            if (j == 6 || j == 7) begin
                n_checks++;
                if (press !== ((j == 6) ? 4'b1111 : 4'b0000) || level !== 4'b1111) begin
                    n_fail++;
                    $display("FAIL reset_press j=%0d press=%b level=%b", j, press, level);
                end
            end
        end
        for (int j = 0; j < 12; j++) begin
            step('0);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_drain j=%0d dut=%h exp=%h", j, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_clean_rise();
        int npress = 0;
        for (int j = 1; j <= 10; j++) begin
            step(4'b0001);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL rise_seq j=%0d dut=%h exp=%h", j, dut_vec, exp_vec);
            end
            if (press[0]) npress++;
            if (j == 6) begin
                n_checks++;
                if (press !== 4'b0001 || level !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL rise_edge press=%b level=%b exp=0001/0001", press, level);
                end
            end
        end
        n_checks++;
        if (npress != 1) begin
            n_fail++;
            $display("FAIL rise_count got=%0d exp=1", npress);
        end
        for (int j = 0; j < 12; j++) begin
            step('0);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL rise_drain j=%0d dut=%h exp=%h", j, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_bounce();
        int npress = 0;
        int nrel   = 0;
        logic [N-1:0] v;
        for (int j = 1; j <= 26; j++) begin
            v = '0;
            v[1] = (j > 12) ? 1'b1 : ((((j - 1) / 2) % 2) == 0);
            step(v);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL bounce_seq j=%0d dut=%h exp=%h", j, dut_vec, exp_vec);
            end
            if (press[1]) npress++;
            if (rel[1]) nrel++;
        end
        n_checks++;
        if (npress != 1 || nrel != 0) begin
            n_fail++;
            $display("FAIL bounce_count press=%0d rel=%0d exp=1/0", npress, nrel);
        end
        for (int j = 0; j < 12; j++) begin
            step('0);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL bounce_drain j=%0d dut=%h exp=%h", j, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_long_repeat();
        int p  = -1;
        int lj = -1;
        int got [$];
        int want [$];
        if (RPT_EN) want = '{25, 30, 35, 40};
        for (int j = 1; j <= 46; j++) begin
            step(4'b0100);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL long_seq j=%0d dut=%h exp=%h", j, dut_vec, exp_vec);
            end
            if (press[2]) p = j;
            if (long_press[2]) lj = j;
            if (rpt[2]) got.push_back(j - p);
        end
        n_checks++;
        if (p != 6 || lj - p != L) begin
            n_fail++;
            $display("FAIL long_time press=%0d long=%0d exp=6/26", p, lj);
        end
        n_checks++;
        if (got.size() != want.size()) begin
            n_fail++;
            $display("FAIL rpt_count got=%0d exp=%0d", got.size(), want.size());
        end else begin
            foreach (want[i]) begin
                n_checks++;
                if (got[i] != want[i]) begin
                    n_fail++;
                    $display("FAIL rpt_offset idx=%0d got=%0d exp=%0d", i, got[i], want[i]);
                end
            end
        end
        for (int j = 0; j < 12; j++) begin
            step('0);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL long_drain j=%0d dut=%h exp=%h", j, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_release_priority();
        int rj    = -1;
        int nlong = 0;
        for (int j = 1; j <= 32; j++) begin
            step((j <= 20) ? 4'b1000 : 4'b0000);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL prio_seq j=%0d dut=%h exp=%h", j, dut_vec, exp_vec);
            end
            if (rel[3]) rj = j;
            if (long_press[3]) nlong++;
        end
        n_checks++;
        if (rj != 26 || nlong != 0) begin
            n_fail++;
            $display("FAIL prio_release rel_at=%0d long_cnt=%0d exp=26/0", rj, nlong);
        end
    endtask

    task automatic test_reset_mid_held();
        for (int j = 1; j <= 30; j++) begin
            step(4'b0100);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL midrst_pre j=%0d dut=%h exp=%h", j, dut_vec, exp_vec);
            end
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec !== '0) begin
            n_fail++;
            $display("FAIL midrst_async dut=%h exp=0", dut_vec);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec !== '0) begin
            n_fail++;
            $display("FAIL midrst_hold dut=%h exp=0", dut_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int j = 1; j <= 8; j++) begin
            step(4'b0100);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL midrst_post j=%0d dut=%h exp=%h", j, dut_vec, exp_vec);
            end
            if (j == 6) begin
                n_checks++;
                if (press !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL midrst_press press=%b exp=0100", press);
                end
            end
        end
        for (int j = 0; j < 12; j++) begin
            step('0);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL midrst_drain j=%0d dut=%h exp=%h", j, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] v = '0;
        int rate = 2;
        for (int j = 0; j < 900; j++) begin
            if ((j % 50) == 0) begin
                case ($urandom_range(0, 2))
                    0:       rate = 2;
                    1:       rate = 8;
                    default: rate = 60;
                endcase
            end
            for (int c = 0; c < int'(N); c++) begin
                if ($urandom_range(0, rate) == 0) v[c] = ~v[c];
            end
            step(v);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random j=%0d btn=%b dut=%h exp=%h", j, v, dut_vec, exp_vec);
            end
        end
    endtask

    initial begin
        btn   = '0;
        rst_n = 1'b0;
        test_reset();
        test_clean_rise();
        test_bounce();
        test_long_repeat();
        test_release_priority();
        test_reset_mid_held();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debounce_multi.md
BTN_DEBOUNCE_MULTI -- requirements
Module: btn_debounce_multi

Interface
REQ-001 The block SHALL have parameter N_BTN, default 4, giving the number of independent button channels (1..32).
REQ-002 The block SHALL have parameter CLOCK_FREQ, default 50_000_000, giving clk frequency in Hz; it must be an integer multiple of 1000, and CYC_PER_MS = CLOCK_FREQ/1000.
REQ-003 The block SHALL have parameter STABLE_MS, default 10, giving the debounce window; STABLE_CYC = STABLE_MS*CYC_PER_MS.
REQ-004 The block SHALL have parameter LONG_MS, default 1000, giving the long-press threshold; LONG_CYC = LONG_MS*CYC_PER_MS.
REQ-005 The block SHALL have parameter REPEAT_MS, default 200, giving the auto-repeat period; REPEAT_CYC = REPEAT_MS*CYC_PER_MS.
REQ-006 The block SHALL have parameter ACTIVE_LOW, default 0; when 1, raw inputs are inverted before synchronisation.
REQ-007 Port clk: input, 1 bit; clock, all state on rising edge.
REQ-008 Port rst_n: input, 1 bit; reset, asynchronous, active-low.
REQ-009 Port btn: input, N_BTN bits; raw asynchronous button inputs.
REQ-010 Port level: output, N_BTN bits; debounced pressed state, registered.
REQ-011 Port press: output, N_BTN bits; one-cycle pulse on debounced press.
REQ-012 Port release: output, N_BTN bits; one-cycle pulse on debounced release.
REQ-013 Port long_press: output, N_BTN bits; one-cycle pulse when the hold reaches LONG_CYC.
REQ-014 Port rpt: output, N_BTN bits; one-cycle auto-repeat pulses while held past the threshold.

Function
REQ-015 Each channel SHALL pass its (optionally inverted) input through a 2-flop synchroniser; s[i] denotes the second flop.
REQ-016 Each channel SHALL have a stable counter of width $clog2(STABLE_CYC+1), cleared whenever s[i]==level[i] and incremented otherwise.
REQ-017 level[i] SHALL toggle on the edge where s[i]!=level[i] has held for STABLE_CYC consecutive cycles, and the stable counter SHALL clear on that same edge.
REQ-018 A clean input step SHALL therefore appear on level[i] exactly 2+STABLE_CYC cycles after the first sampling edge.
REQ-019 press[i] or release[i] SHALL assert in the same cycle level[i] rises or falls, for exactly one cycle.
REQ-020 Each channel SHALL run an FSM with states RELEASED, PRESSED, HELD, and reset to RELEASED.
REQ-021 RELEASED->PRESSED on debounced rise; PRESSED->HELD when the hold counter reaches LONG_CYC; PRESSED or HELD->RELEASED on debounced fall.
REQ-022 The hold counter SHALL clear on debounced rise and increment each cycle in PRESSED; long_press[i] SHALL pulse on the PRESSED->HELD edge, i.e. LONG_CYC cycles after press[i].
REQ-023 In HELD the repeat counter SHALL count 1..REPEAT_CYC; rpt[i] SHALL pulse each time it reaches REPEAT_CYC and the counter SHALL wrap to 0, giving the first rpt at LONG_CYC+REPEAT_CYC after press[i].
REQ-024 A debounced fall in the same cycle as a long or repeat threshold SHALL take priority: release[i] pulses and long_press[i]/rpt[i] SHALL NOT pulse.
REQ-025 Channels SHALL be fully independent; simultaneous events on any subset SHALL produce simultaneous pulses.
REQ-026 All outputs SHALL be driven directly from flops, with no combinational path from btn.

Reset
REQ-027 rst_n low SHALL immediately clear synchronisers, counters, level, press, release, long_press and rpt to 0, and the FSMs to RELEASED.
REQ-028 After reset release with a button held, that button SHALL be reported as a fresh press 2+STABLE_CYC cycles later.

Configuration
REQ-029 Macro BTN_DEBOUNCE_AUTOREPEAT_EN, when defined, SHALL compile in the repeat counters and rpt generation (REQ-023).
REQ-030 Without BTN_DEBOUNCE_AUTOREPEAT_EN, rpt SHALL be constant 0, no repeat counter SHALL exist, and all other behaviour SHALL be unchanged.

Verification
Bench parameters: CLOCK_FREQ=1000, STABLE_MS=4, LONG_MS=20, REPEAT_MS=5, N_BTN=4 (1 cycle = 1 ms).
REQ-031 Reset with btn=4'b1111 -> all outputs 0 during reset; 6 cycles after release, press=4'b1111 for 1 cycle and level=4'b1111.
REQ-032 Clean btn[0] rise at cycle 0 -> level[0]=1 and press[0]=1 at cycle 6 only; bits 3..1 stay 0.
REQ-033 btn[1] toggled every 2 cycles for 12 cycles, then held 1 -> exactly one press[1], no release[1].
REQ-034 btn[2] held 40 cycles with macro defined -> long_press[2] at press+20 and rpt[2] at press+25, +30, +35, +40; without the macro, rpt stays 0.
REQ-035 btn[3] falls so that the debounced fall coincides with press+20 -> release[3] pulses and long_press[3] does not.
REQ-036 rst_n pulsed low mid-HELD on channel 2 -> all outputs 0 at once; with btn still held, press[2] recurs 6 cycles after reset release.
